// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - mode encodings and LFSR constants for led_pattern_gen
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_BIN    = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_LFSR   = 2'd2,
      MODE_BOUNCE = 2'd3
   } mode_t;

   localparam logic [31:0] LFSR_MASK         = 32'h80200003;
   localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h00010000;

   // Galois right-shift step; a stuck-at-zero state recovers through the seed.
   function automatic logic [31:0] lfsr_advance(input logic [31:0] state,
                                                input logic [31:0] seed);
      logic [31:0] shifted;
      shifted = {1'b0, state[31:1]};
      if (state == 32'd0)
         lfsr_advance = seed;
      else if (state[0])
         lfsr_advance = shifted ^ LFSR_MASK;
      else
         lfsr_advance = shifted;
   endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - wrapping step prescaler with hold and synchronous clear
module led_prescaler #(
   parameter int WIDTH = 22
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic clear,
   output logic tick_req
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (!hold)
         cnt <= cnt + 1'b1;
   end

   assign tick_req = (&cnt) && !hold;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator (binary/gray/LFSR/bounce); optional PWM via LED_PATTERN_PWM_EN
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int          LED_COUNT = 5,
   parameter int          LOG2DELAY = 22,
   parameter logic [31:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic                 pause,
   input  logic                 step,
   input  logic [3:0]           duty,
   output logic [LED_COUNT-1:0] leds,
   output logic                 tick
);

   localparam logic [LED_COUNT-1:0] ONE = LED_COUNT'(1);

   mode_t                mode_sel;
   mode_t                mode_q;
   logic                 mode_change;
   logic                 tick_req;
   logic                 advance;

   logic [LED_COUNT-1:0] cnt, cnt_n;
   logic [31:0]          lfsr, lfsr_n;
   logic [LED_COUNT-1:0] pos, pos_n;
   logic                 up, up_n;
   logic [LED_COUNT-1:0] pattern;

   assign mode_sel    = mode_t'(mode);
   assign mode_change = (mode_sel != mode_q);
   assign advance     = !mode_change && (tick_req || (step && pause));

   led_prescaler #(.WIDTH(LOG2DELAY)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .hold     (pause),
      .clear    (mode_change),
      .tick_req (tick_req)
   );

   always_comb begin
      cnt_n  = cnt;
      lfsr_n = lfsr;
      pos_n  = pos;
      up_n   = up;
      if (mode_change) begin
         case (mode_sel)
            MODE_BIN, MODE_GRAY: cnt_n  = '0;
            MODE_LFSR:           lfsr_n = LFSR_SEED;
            default: begin
               pos_n = ONE;
               up_n  = 1'b1;
            end
         endcase
      end else if (advance) begin
         case (mode_sel)
            MODE_BIN, MODE_GRAY: cnt_n  = cnt + ONE;
            MODE_LFSR:           lfsr_n = lfsr_advance(lfsr, LFSR_SEED);
            default: begin
               pos_n = up ? {pos[LED_COUNT-2:0], 1'b0} : {1'b0, pos[LED_COUNT-1:1]};
               // Flip on arrival so each end is lit for exactly one step.
               if (pos_n[LED_COUNT-1])
                  up_n = 1'b0;
               else if (pos_n[0])
                  up_n = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      pattern = '0;
      case (mode_sel)
         MODE_BIN:  pattern = cnt_n;
         MODE_GRAY: pattern = cnt_n ^ (cnt_n >> 1);
         MODE_LFSR: pattern = lfsr_n[LED_COUNT-1:0];
         default:   pattern = pos_n;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= MODE_BIN;
         cnt    <= '0;
         lfsr   <= LFSR_SEED;
         pos    <= ONE;
         up     <= 1'b1;
         tick   <= 1'b0;
      end else begin
         mode_q <= mode_sel;
         cnt    <= cnt_n;
         lfsr   <= lfsr_n;
         pos    <= pos_n;
         up     <= up_n;
         tick   <= advance;
      end
   end

`ifdef LED_PATTERN_PWM_EN
   logic [3:0] pwm_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= 4'd0;
         leds    <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 4'd1;
         leds    <= (pwm_cnt >= duty) ? '0 : pattern;
      end
   end
`else
   logic unused_duty;
   assign unused_duty = ^duty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         leds <= '0;
      else
         leds <= pattern;
   end
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen against a behavioural model
module tb_led_pattern_gen;

   localparam int          N    = 5;
   localparam int          LD   = 2;
   localparam int          PER  = 2 ** LD;
   localparam logic [31:0] SEED = 32'h00010000;
   localparam logic [31:0] MASK = 32'h80200003;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   mode = 2'd0;
   logic         pause = 1'b0;
   logic         step = 1'b0;
   logic [3:0]   duty = 4'd0;
   logic [N-1:0] leds;
   logic         tick;

   int checks = 0;
   int failures = 0;
   int mq = 0;
   int adv = 0;
   int pc = 0;
   int tick_cnt = 0;
   logic [N-1:0] exp_leds = '0;
   logic         exp_tick = 1'b0;

   always #5 clk = ~clk;

   led_pattern_gen #(.LED_COUNT(N), .LOG2DELAY(LD), .LFSR_SEED(SEED)) dut (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .pause (pause),
      .step  (step),
      .duty  (duty),
      .leds  (leds),
      .tick  (tick)
   );

   // Pattern shown after n advances since the mode was (re)selected.
   function automatic logic [N-1:0] pattern_of(input int m, input int n);
      logic [31:0] s;
      int c, p, idx;
      pattern_of = '0;
      case (m)
         0: pattern_of = N'(n % (1 << N));
         1: begin
            c = n % (1 << N);
            pattern_of = N'(c ^ (c >> 1));
         end
         2: begin
            s = SEED;
            for (int i = 0; i < n; i++)
               s = (s == 0) ? SEED : ((s >> 1) ^ (s[0] ? MASK : 32'd0));
            pattern_of = s[N-1:0];
         end
         default: begin
            p   = n % (2 * (N - 1));
            idx = (p <= N - 1) ? p : 2 * (N - 1) - p;
            pattern_of = N'(1 << idx);
         end
      endcase
   endfunction

   task automatic check_val(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int m, input logic p, input logic s);
      logic a;
      mode  = m[1:0];
      pause = p;
      step  = s;
      @(posedge clk);
      if (m != mq) begin
         mq = m;
         adv = 0;
         pc = 0;
         exp_tick = 1'b0;
      end else begin
         a = ((pc == PER - 1) && !p) || (s && p);
         if (!p) pc = (pc + 1) % PER;
         if (a) adv++;
         exp_tick = a;
      end
      exp_leds = pattern_of(mq, adv);
      #1;
      if (tick === 1'b1) tick_cnt++;
      check_val("leds", int'(leds), int'(exp_leds));
      check_val("tick", int'(tick), int'(exp_tick));
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      check_val("rst_leds", int'(leds), 0);
      check_val("rst_tick", int'(tick), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq = 0;
      adv = 0;
      pc = 0;
   endtask

   initial begin
      int m, len;
      logic p;
      logic [N-1:0] held;

      mode = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_leds", int'(leds), 0);
      check_val("reset_tick", int'(tick), 0);
      rst = 1'b0;

      // binary through a full wrap
      for (int i = 0; i < 33 * PER; i++) cyc(0, 1'b0, 1'b0);

      // gray, bounce and LFSR directed runs
      for (int i = 0; i < 8 * PER; i++) cyc(1, 1'b0, 1'b0);
      for (int i = 0; i < 12 * PER; i++) cyc(3, 1'b0, 1'b0);
      for (int i = 0; i < 20 * PER; i++) cyc(2, 1'b0, 1'b0);

      // pause holds everything
      cyc(0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) cyc(0, 1'b0, 1'b0);
      held = leds;
      tick_cnt = 0;
      for (int i = 0; i < 40; i++) cyc(0, 1'b1, 1'b0);
      check_val("pause_leds", int'(leds), int'(held));
      check_val("pause_ticks", tick_cnt, 0);

      // three step pulses while paused
      tick_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1'b1, 1'b1);
         cyc(0, 1'b1, 1'b0);
      end
      check_val("step_ticks", tick_cnt, 3);
      check_val("step_leds", int'(leds), int'(N'((int'(held) + 3) % (1 << N))));

      // step with pause low is ignored, even alongside a request
      tick_cnt = 0;
      for (int i = 0; i < 2 * PER; i++) cyc(0, 1'b0, 1'b1);
      check_val("step_nopause_ticks", tick_cnt, 2);

      // mid-run switch to bounce
      cyc(0, 1'b0, 1'b0);
      cyc(3, 1'b0, 1'b0);
      check_val("switch_bounce", int'(leds), 1);
      for (int i = 0; i < 3 * PER; i++) cyc(3, 1'b0, 1'b0);

      // asynchronous reset mid-run
      do_reset();
      for (int i = 0; i < 3 * PER; i++) cyc(3, 1'b0, 1'b0);

      // randomized segments
      for (int k = 0; k < 14; k++) begin
         m   = int'($urandom_range(0, 3));
         len = int'($urandom_range(20, 90));
         p   = 1'b0;
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 9) == 0) p = ~p;
            cyc(m, p, ($urandom_range(0, 4) == 0));
         end
         if (k == 7) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
